// File: rtl/w_stage_writeback.sv
// W-stage write-back: decodes the instruction in W, commits to the 32x32
// general register file, serves the two D-stage read ports with
// write-before-read bypass, and counts committed writes.
module w_stage_writeback #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         W_PC,
  input  logic [31:0]         W_Instr,
  input  logic [31:0]         W_ALUout,
  input  logic [31:0]         W_DMout,
  input  logic [4:0]          D_rs_addr,
  input  logic [4:0]          D_rt_addr,
  output logic [31:0]         D_rs_data,
  output logic [31:0]         D_rt_data,
  output logic                W_RegWrite,
  output logic [4:0]          W_A3,
  output logic [31:0]         W_WD,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  logic [31:0]         grf_q [32];
  logic [RETIRE_W-1:0] cnt_q, cnt_d;
  logic [5:0]          op, funct;
  logic                dec_we;
  logic [4:0]          dec_a3;
  logic [31:0]         dec_wd;
  logic                pc_at_reset, bubble;

  assign op    = W_Instr[31:26];
  assign funct = W_Instr[5:0];

  // An all-zero word is a bubble for any PC, the post-reset PC included;
  // the PC comparison therefore cannot change the outcome.
  assign pc_at_reset = (W_PC == PC_RESET);
  assign bubble      = (W_Instr == 32'h0) & (pc_at_reset | ~pc_at_reset);

  // Decode destination and write-back source from the instruction word.
  always_comb begin
    dec_we = 1'b0;
    dec_a3 = 5'd0;
    dec_wd = 32'h0;
    unique case (op)
      OP_RTYPE: if (funct == FN_ADD || funct == FN_SUB) begin
        dec_we = 1'b1;
        dec_a3 = W_Instr[15:11];
        dec_wd = W_ALUout;
      end
      OP_ORI, OP_LUI: begin
        dec_we = 1'b1;
        dec_a3 = W_Instr[20:16];
        dec_wd = W_ALUout;
      end
      OP_LW: begin
        dec_we = 1'b1;
        dec_a3 = W_Instr[20:16];
        dec_wd = W_DMout;
      end
      OP_JAL: begin
        dec_we = 1'b1;
        dec_a3 = 5'd31;
        dec_wd = W_PC + 32'd8;
      end
      default: ;
    endcase
  end

  // Writes to $0 and bubbles are squashed so hazard logic sees no write.
  always_comb begin
    W_RegWrite = dec_we && (dec_a3 != 5'd0) && !bubble;
    W_A3       = W_RegWrite ? dec_a3 : 5'd0;
    W_WD       = W_RegWrite ? dec_wd : 32'h0;
  end

  // Next retire count; wraps naturally at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (W_RegWrite) cnt_d = cnt_q + 1'b1;
  end

  // GRF and counter: reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'h0;
      cnt_q <= '0;
    end else begin
      if (W_RegWrite) grf_q[W_A3] <= W_WD;
      cnt_q <= cnt_d;
    end
  end

  // Read ports: $0 reads zero, then W bypass, then the array.
  always_comb begin
    D_rs_data = grf_q[D_rs_addr];
    if (D_rs_addr == 5'd0)                        D_rs_data = 32'h0;
    else if (W_RegWrite && D_rs_addr == W_A3)     D_rs_data = W_WD;
    D_rt_data = grf_q[D_rt_addr];
    if (D_rt_addr == 5'd0)                        D_rt_data = 32'h0;
    else if (W_RegWrite && D_rt_addr == W_A3)     D_rt_data = W_WD;
  end

  assign retire_count = cnt_q;

endmodule

// File: tb/tb_w_stage_writeback.sv
// Directed vector bench for w_stage_writeback: a table of W-stage inputs with
// hand-computed combinational outputs and post-edge retire counts.
module tb_w_stage_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_PC, W_Instr, W_ALUout, W_DMout;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rs_data, D_rt_data, W_WD;
  logic        W_RegWrite;
  logic [4:0]  W_A3;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  w_stage_writeback dut (
    .clk(clk), .reset(reset), .W_PC(W_PC), .W_Instr(W_Instr),
    .W_ALUout(W_ALUout), .W_DMout(W_DMout), .D_rs_addr(D_rs_addr),
    .D_rt_addr(D_rt_addr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .W_RegWrite(W_RegWrite), .W_A3(W_A3), .W_WD(W_WD),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr, pc, alu, dm;
    logic [4:0]  rs, rt;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd, rs_d, rt_d, cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //               rst instr          pc             alu            dm             rs  rt  we a3  wd             rs_d           rt_d           cnt
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_3000, 32'h0000_0009, 32'h0000_0009, 0,  5,  0, 0,  32'h0,         32'h0,         32'h0,         0};
    vecs[1]  = '{1'b0, 32'h3401_1234, 32'h0000_3000, 32'h0000_1234, 32'h0,         1,  2,  1, 1,  32'h0000_1234, 32'h0000_1234, 32'h0,         1};
    vecs[2]  = '{1'b0, 32'h8C02_0000, 32'h0000_3004, 32'h0000_0005, 32'hDEAD_BEEF, 1,  2,  1, 2,  32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 2};
    vecs[3]  = '{1'b0, 32'hAC02_0000, 32'h0000_3008, 32'h0000_0005, 32'h0,         2,  1,  0, 0,  32'h0,         32'hDEAD_BEEF, 32'h0000_1234, 2};
    vecs[4]  = '{1'b0, 32'h0C00_0C00, 32'h0000_3008, 32'h0,         32'h0,         31, 2,  1, 31, 32'h0000_3010, 32'h0000_3010, 32'hDEAD_BEEF, 3};
    vecs[5]  = '{1'b0, 32'h0C00_0C00, 32'hFFFF_FFFC, 32'h0,         32'h0,         31, 31, 1, 31, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004, 4};
    vecs[6]  = '{1'b0, 32'h0022_0020, 32'h0000_3010, 32'h0000_0007, 32'h0,         0,  0,  0, 0,  32'h0,         32'h0,         32'h0,         4};
    vecs[7]  = '{1'b0, 32'h0022_1820, 32'h0000_3014, 32'h0000_0077, 32'h0,         3,  3,  1, 3,  32'h0000_0077, 32'h0000_0077, 32'h0000_0077, 5};
    vecs[8]  = '{1'b0, 32'h1022_0000, 32'h0000_3018, 32'h0000_0011, 32'h0,         3,  31, 0, 0,  32'h0,         32'h0000_0077, 32'h0000_0004, 5};
    vecs[9]  = '{1'b0, 32'h03E0_0008, 32'h0000_301C, 32'h0000_0022, 32'h0,         1,  3,  0, 0,  32'h0,         32'h0000_1234, 32'h0000_0077, 5};
    vecs[10] = '{1'b0, 32'h0022_2022, 32'h0000_3020, 32'h0000_A5A5, 32'h0,         4,  0,  1, 4,  32'h0000_A5A5, 32'h0000_A5A5, 32'h0,         6};
    vecs[11] = '{1'b0, 32'h3C05_FFFF, 32'h0000_3024, 32'hFFFF_0000, 32'h0,         5,  4,  1, 5,  32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_A5A5, 7};
    vecs[12] = '{1'b0, 32'h3401_0001, 32'h0000_3028, 32'h0000_0001, 32'h0,         1,  2,  1, 1,  32'h0000_0001, 32'h0000_0001, 32'hDEAD_BEEF, 8};
    vecs[13] = '{1'b0, 32'h3401_0002, 32'h0000_302C, 32'h0000_0002, 32'h0,         1,  2,  1, 1,  32'h0000_0002, 32'h0000_0002, 32'hDEAD_BEEF, 9};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0000_3030, 32'h0000_0033, 32'h0000_0033, 1,  2,  0, 0,  32'h0,         32'h0000_0002, 32'hDEAD_BEEF, 9};
    vecs[15] = '{1'b0, 32'hFC01_0000, 32'h0000_3034, 32'h0000_0044, 32'h0000_0044, 1,  5,  0, 0,  32'h0,         32'h0000_0002, 32'hFFFF_0000, 9};
    vecs[16] = '{1'b1, 32'h3401_FFFF, 32'h0000_3038, 32'h0000_FFFF, 32'h0,         1,  3,  1, 1,  32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0077, 0};
    vecs[17] = '{1'b0, 32'h0000_0000, 32'h0000_3000, 32'h0,         32'h0,         1,  3,  0, 0,  32'h0,         32'h0,         32'h0,         0};

    // Reset with a bubble in W.
    reset = 1'b1; W_PC = 32'h0000_3000; W_Instr = 32'h0; W_ALUout = 32'h0;
    W_DMout = 32'h0; D_rs_addr = 5'd0; D_rt_addr = 5'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_count", retire_count, 32'h0);
    check("reset_we", {31'h0, W_RegWrite}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      D_rs_addr = 5'(a);
      D_rt_addr = 5'(31 - a);
      #1;
      check($sformatf("reset_rs[%0d]", a), D_rs_data, 32'h0);
      check($sformatf("reset_rt[%0d]", 31 - a), D_rt_data, 32'h0);
    end

    // Table: drive, check combinational outputs, clock, check counter.
    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst; W_Instr = vecs[i].instr; W_PC = vecs[i].pc;
      W_ALUout = vecs[i].alu; W_DMout = vecs[i].dm;
      D_rs_addr = vecs[i].rs; D_rt_addr = vecs[i].rt;
      #1;
      check($sformatf("v%0d_we", i), {31'h0, W_RegWrite}, {31'h0, vecs[i].we});
      check($sformatf("v%0d_a3", i), {27'h0, W_A3}, {27'h0, vecs[i].a3});
      check($sformatf("v%0d_wd", i), W_WD, vecs[i].wd);
      check($sformatf("v%0d_rs", i), D_rs_data, vecs[i].rs_d);
      check($sformatf("v%0d_rt", i), D_rt_data, vecs[i].rt_d);
      @(posedge clk); #1;
      check($sformatf("v%0d_cnt", i), retire_count, vecs[i].cnt);
    end

    // Post-reset sweep: every register cleared, including ones written above.
    reset = 1'b0; W_Instr = 32'h0;
    for (int a = 1; a < 32; a++) begin
      D_rs_addr = 5'(a);
      D_rt_addr = 5'(a);
      #1;
      check($sformatf("post_rs[%0d]", a), D_rs_data, 32'h0);
      check($sformatf("post_rt[%0d]", a), D_rt_data, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule

// File: doc/w_stage_writeback.md
Name: w_stage_writeback

Overview:
- W-stage consumer of the M/W pipeline register outputs, plus the architectural general register file (GRF).
- Decodes W_Instr to choose destination register and write-back source, then commits to a 32x32 GRF on the rising clock edge.
- Serves the two D-stage read ports, with internal write-to-read bypass.
- Exports W-stage write info for hazard/forwarding logic and keeps a retired-write counter for verification.

Parameters:
- PC_RESET, 32'h0000_3000, PC value that marks a bubble after pipeline reset; its only use is the bubble rule below.
- RETIRE_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears GRF and counter.
- W_PC  input  32  PC of the instruction in W.
- W_Instr  input  32  instruction word in W; 32'h0 is a bubble/nop.
- W_ALUout  input  32  ALU result carried to W.
- W_DMout  input  32  data-memory read data carried to W.
- D_rs_addr  input  5  D-stage read address A1.
- D_rt_addr  input  5  D-stage read address A2.
- D_rs_data  output  32  GRF[A1] with bypass.
- D_rt_data  output  32  GRF[A2] with bypass.
- W_RegWrite  output  1  instruction in W writes a nonzero register this cycle.
- W_A3  output  5  destination register; 5'd0 when no write.
- W_WD  output  32  write-back data; 32'h0 when no write.
- retire_count  output  RETIRE_W  number of GRF writes committed since reset.

Behaviour:
Decode, combinational from W_Instr (op = [31:26], funct = [5:0]):
- op 000000, funct 100000 (add) or 100010 (sub): A3 = rd [15:11], WD = W_ALUout.
- op 001101 (ori) or 001111 (lui): A3 = rt [20:16], WD = W_ALUout.
- op 100011 (lw): A3 = rt, WD = W_DMout.
- op 000011 (jal): A3 = 31, WD = W_PC + 8, modulo 2^32 (wraps).

No-write cases (W_RegWrite = 0, W_A3 = 0, W_WD = 0):
- sw, beq, jr (op 000000, funct 001000), the nop word 32'h0, and any other op/funct.
- Any decoded A3 = 0. Writes to $0 are dropped, are not counted, and $0 always reads 0.

Bubble:
- W_Instr = 0 is a bubble whatever the value of W_PC, including PC_RESET after reset. A bubble never writes.

GRF write:
- On posedge clk, if reset = 0 and W_RegWrite = 1, then GRF[W_A3] <= W_WD and retire_count <= retire_count + 1.
- retire_count wraps from all-ones to 0.

Reset:
- On posedge clk with reset = 1, GRF[1..31] <= 0 and retire_count <= 0.
- Any W write pending in that cycle is discarded.
- After reset every read returns 0 and retire_count = 0.
- W_RegWrite, W_A3 and W_WD follow the inputs combinationally; they are 0 once the upstream register presents its reset values (W_Instr = 0).

Read:
- Combinational, zero latency.
- D_x_data = 0 if the address is 0.
- Otherwise, if W_RegWrite = 1 and the address equals W_A3, D_x_data = W_WD (same-cycle bypass, i.e. write-before-read).
- Otherwise D_x_data = GRF[address].
- Both ports are independent. Both may hit the bypass at once.

Simultaneous events:
- reset and a valid write in the same cycle: reset wins.
- Back-to-back writes to the same register: the last one wins; each is counted.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 32'h0; retire_count = 0; with W_Instr = 0, W_RegWrite = 0.
- ori $1 (W_Instr = 32'h3401_1234), W_ALUout = 32'h1234; in the same cycle read A1 = 1 -> D_rs_data = 32'h1234 (bypass). After the edge, GRF[1] = 32'h1234 and retire_count = 1.
- lw $2 (32'h8C02_0000), W_DMout = 32'hDEAD_BEEF, W_ALUout = 32'h5 -> GRF[2] = 32'hDEAD_BEEF, not 5. Then sw (32'hAC02_0000) -> no write; count unchanged.
- jal (32'h0C00_0C00), W_PC = 32'h0000_3008 -> W_A3 = 31, GRF[31] = 32'h0000_3010. Repeat with W_PC = 32'hFFFF_FFFC -> GRF[31] = 32'h0000_0004 (wrap).
- add with rd = 0 (32'h0022_0020), W_ALUout = 32'h7 -> W_RegWrite = 0; reading A1 = A2 = 0 returns 0 and count is unchanged. Then add $3 (32'h0022_1820) with both A1 and A2 = 3 -> both ports show W_WD in the same cycle.
- With GRF[1] = 32'h1234, assert reset in the same cycle as ori $1 = 32'hFFFF -> after the edge, GRF[1] = 0 and retire_count = 0; the write is discarded.
